// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: normalisation stage that follows the leading-zero counter.
// The stage takes a data word, its exponent and its leading-zero count.
// It left-shifts the word so that the MSB is 1.
// It lowers the exponent by the shift amount.
// The pipeline has two registered stages (S1 captures the input, S2 holds the result).
// Optional build macro: LZC_NORM_CHECK_EN adds the sticky lzc_err output.
// LZC_NORM_CHECK_EN makes S1 recompute the leading-zero count and compare it.
//
// Handshake: a beat moves across an interface on a rising edge when valid && ready.
// A producer holds valid and its payload stable until that edge.
// ready can depend combinationally on downstream ready (in_ready follows out_ready
// through s2_adv). Valid never depends on ready.
module lzc_norm_pipe #(
  parameter int WI_SZ  = 32,
  parameter int WO_SZ  = $clog2(WI_SZ) + 1,
  parameter int EXP_SZ = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WI_SZ-1:0]  in_data,
  input  logic [WO_SZ-1:0]  in_lzc,
  input  logic [EXP_SZ-1:0] in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WI_SZ-1:0]  out_data,
  output logic [EXP_SZ-1:0] out_exp,
  output logic              out_zero,
`ifdef LZC_NORM_CHECK_EN
  output logic              out_uflow,
  output logic              lzc_err
`else
  output logic              out_uflow
`endif
);

  // Common width for the unsigned exponent-versus-count compare.
  localparam int CW = (EXP_SZ > WO_SZ) ? EXP_SZ : WO_SZ;
  localparam logic [WO_SZ-1:0] LZC_MAX = WO_SZ'(WI_SZ);

  logic              s1_valid_q;
  logic [WI_SZ-1:0]  s1_data_q;
  logic [WO_SZ-1:0]  s1_lzc_q;
  logic [EXP_SZ-1:0] s1_exp_q;

  logic              s2_valid_q;
  logic [WI_SZ-1:0]  out_data_q, out_data_d;
  logic [EXP_SZ-1:0] out_exp_q, out_exp_d;
  logic              out_zero_q, out_zero_d;
  logic              out_uflow_q, out_uflow_d;

  logic              s1_load;
  logic              s2_adv;

  logic [WO_SZ-1:0]  lzc_c;
  logic [CW-1:0]     exp_x;
  logic [CW-1:0]     lzc_x;

  // S2 takes the S1 beat when S2 is empty or S2 is draining this cycle.
  // S1 takes a new beat when it is empty or when its beat moves on.
  // in_ready is held low during reset.
  assign s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = rst_n && (!s1_valid_q || s2_adv);
  assign s1_load  = in_valid && in_ready;

  // S1 capture register: holds the beat until S2 takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_lzc_q   <= '0;
      s1_exp_q   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= in_data;
        s1_lzc_q   <= in_lzc;
        s1_exp_q   <= in_exp;
      end else if (s2_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // Normalise arithmetic on the S1 registers.
  // Counts above WI_SZ are clamped to WI_SZ, which means a zero word.
  // When the exponent is smaller than the count, the shift stops at the exponent.
  always_comb begin
    lzc_c       = (s1_lzc_q > LZC_MAX) ? LZC_MAX : s1_lzc_q;
    exp_x       = CW'(s1_exp_q);
    lzc_x       = CW'(lzc_c);
    out_data_d  = '0;
    out_exp_d   = '0;
    out_zero_d  = 1'b0;
    out_uflow_d = 1'b0;
    if (lzc_c == LZC_MAX) begin
      out_zero_d = 1'b1;
    end else if (exp_x >= lzc_x) begin
      out_data_d = s1_data_q << lzc_c;
      out_exp_d  = EXP_SZ'(exp_x - lzc_x);
    end else begin
      // exp < lzc < WI_SZ here, so the exponent fits the shift-amount width
      out_uflow_d = 1'b1;
      out_data_d  = s1_data_q << exp_x[WO_SZ-1:0];
    end
  end

  // S2 result register: it loads on advance, holds while stalled, and empties when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_exp_q   <= '0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_q  <= 1'b1;
        out_data_q  <= out_data_d;
        out_exp_q   <= out_exp_d;
        out_zero_q  <= out_zero_d;
        out_uflow_q <= out_uflow_d;
      end else if (out_ready) begin
        s2_valid_q  <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_exp   = out_exp_q;
  assign out_zero  = out_zero_q;
  assign out_uflow = out_uflow_q;

`ifdef LZC_NORM_CHECK_EN
  logic [WO_SZ-1:0] s1_lzc_calc;
  logic             lzc_err_q;

  // Recount the leading zeros of the S1 word.
  // The highest set bit is the last one the loop writes, so it sets the result.
  always_comb begin
    s1_lzc_calc = LZC_MAX;
    for (int i = 0; i < WI_SZ; i++) begin
      if (s1_data_q[i]) s1_lzc_calc = WO_SZ'(WI_SZ - 1 - i);
    end
  end

  // Sticky error flag: it sets on the first mismatch and clears only on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lzc_err_q <= 1'b0;
    end else if (s1_valid_q && (s1_lzc_calc != s1_lzc_q)) begin
      lzc_err_q <= 1'b1;
    end
  end

  assign lzc_err = lzc_err_q;
`endif

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Directed testbench for lzc_norm_pipe.
// The expected values are computed by hand from the normalisation rules.
module tb_lzc_norm_pipe;

  localparam int WI_SZ  = 32;
  localparam int WO_SZ  = 6;
  localparam int EXP_SZ = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WI_SZ-1:0]  in_data;
  logic [WO_SZ-1:0]  in_lzc;
  logic [EXP_SZ-1:0] in_exp;
  logic              out_valid;
  logic              out_ready;
  logic [WI_SZ-1:0]  out_data;
  logic [EXP_SZ-1:0] out_exp;
  logic              out_zero;
  logic              out_uflow;
`ifdef LZC_NORM_CHECK_EN
  logic              lzc_err;
`endif

  int n_vec;
  int n_err;
  logic [EXP_SZ-1:0] exp_q[$];

  lzc_norm_pipe #(.WI_SZ(WI_SZ), .WO_SZ(WO_SZ), .EXP_SZ(EXP_SZ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_lzc    (in_lzc),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_exp   (out_exp),
    .out_zero  (out_zero),
`ifdef LZC_NORM_CHECK_EN
    .out_uflow (out_uflow),
    .lzc_err   (lzc_err)
`else
    .out_uflow (out_uflow)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one beat into an empty pipe while out_ready=1.
  // Check that out_valid is still low after the accept edge.
  // Check that out_valid and the result fields are correct after the next edge.
  task automatic apply(input string tag, input logic [WI_SZ-1:0] d, input logic [WO_SZ-1:0] l,
                       input logic [EXP_SZ-1:0] e, input logic [WI_SZ-1:0] x_data,
                       input logic [EXP_SZ-1:0] x_exp, input logic x_zero, input logic x_uflow);
    in_valid  = 1'b1;
    in_data   = d;
    in_lzc    = l;
    in_exp    = e;
    out_ready = 1'b1;
    #1;
    check_eq({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq({tag, "_vld"},   64'(out_valid), 64'd1);
    check_eq({tag, "_data"},  64'(out_data),  64'(x_data));
    check_eq({tag, "_exp"},   64'(out_exp),   64'(x_exp));
    check_eq({tag, "_zero"},  64'(out_zero),  64'(x_zero));
    check_eq({tag, "_uflow"}, 64'(out_uflow), 64'(x_uflow));
  endtask

  initial begin
    logic [EXP_SZ-1:0] bp_exp [4];
    int sent;
    int got;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_lzc = '0;
    in_exp = '0;
    out_ready = 1'b0;
    bp_exp[0] = 8'd10; bp_exp[1] = 8'd20; bp_exp[2] = 8'd30; bp_exp[3] = 8'd40;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ovld",  64'(out_valid), 64'd0);
    check_eq("rst_irdy",  64'(in_ready),  64'd0);
    check_eq("rst_data",  64'(out_data),  64'd0);
    check_eq("rst_exp",   64'(out_exp),   64'd0);
    check_eq("rst_zero",  64'(out_zero),  64'd0);
    check_eq("rst_uflow", 64'(out_uflow), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // normalisation cases
    apply("norm",   32'h0000_1000, 6'd19, 8'd100, 32'h8000_0000, 8'd81, 1'b0, 1'b0);
    apply("zero",   32'h0000_0000, 6'd32, 8'd50,  32'h0000_0000, 8'd0,  1'b1, 1'b0);
    apply("uflow",  32'h0000_0001, 6'd31, 8'd10,  32'h0000_0400, 8'd0,  1'b0, 1'b1);
    apply("eqexp",  32'h0000_0001, 6'd31, 8'd31,  32'h8000_0000, 8'd0,  1'b0, 1'b0);
    apply("noshft", 32'hC000_0000, 6'd0,  8'd0,   32'hC000_0000, 8'd0,  1'b0, 1'b0);
    apply("lzc1",   32'h7FFF_FFFF, 6'd1,  8'd255, 32'hFFFF_FFFE, 8'd254, 1'b0, 1'b0);
    apply("clamp",  32'h0000_0000, 6'd40, 8'd7,   32'h0000_0000, 8'd0,  1'b1, 1'b0);
    apply("uf0",    32'h0000_00F0, 6'd24, 8'd0,   32'h0000_00F0, 8'd0,  1'b0, 1'b1);
    @(posedge clk); #1;

    // Backpressure: 4 beats, with out_ready low in cycles 2 to 4.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid  = (sent < 4);
      in_data   = 32'h8000_0000;
      in_lzc    = 6'd0;
      in_exp    = bp_exp[(sent < 4) ? sent : 3];
      out_ready = !(cyc >= 2 && cyc < 5);
      #1;
      if (cyc >= 2 && cyc < 5) begin
        check_eq("bp_irdy_low", 64'(in_ready),  64'd0);
        check_eq("bp_hold_vld", 64'(out_valid), 64'd1);
        check_eq("bp_hold_exp", 64'(out_exp),   64'd10);
        check_eq("bp_hold_dat", 64'(out_data),  64'h8000_0000);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("bp_extra", 64'(out_exp), 64'hFFFF);
        end else begin
          check_eq("bp_order", 64'(out_exp), 64'(exp_q.pop_front()));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_exp);
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq("bp_got",   64'(got),          64'd4);
    check_eq("bp_qempt", 64'(exp_q.size()), 64'd0);

    // reset with two beats in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0100;
    in_lzc    = 6'd23;
    in_exp    = 8'd60;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("mr_full_vld", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_ovld", 64'(out_valid), 64'd0);
    check_eq("mr_irdy", 64'(in_ready),  64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("mr_irdy_rel", 64'(in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check_eq("mr_no_out", 64'(out_valid), 64'd0);
    end
    apply("post_rst", 32'h0000_0100, 6'd23, 8'd60, 32'h8000_0000, 8'd37, 1'b0, 1'b0);

`ifdef LZC_NORM_CHECK_EN
    // lzc cross-check: after a wrong count the flag sets and stays set until reset
    @(posedge clk); #1;
    check_eq("err_init", 64'(lzc_err), 64'd0);
    apply("bad_lzc", 32'h8000_0000, 6'd5, 8'd10, 32'h0000_0000, 8'd5, 1'b0, 1'b0);
    check_eq("err_set", 64'(lzc_err), 64'd1);
    apply("good_lzc", 32'h0001_0000, 6'd15, 8'd20, 32'h8000_0000, 8'd5, 1'b0, 1'b0);
    check_eq("err_sticky", 64'(lzc_err), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("err_clr", 64'(lzc_err), 64'd0);
    rst_n = 1'b1;
`endif

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lzc_norm_pipe.md
Name: lzc_norm_pipe

Overview:
- Normalisation stage directly downstream of the leading-zero counter.
- Consumes a data word, its exponent and the leading-zero count produced for that word.
- Left-shifts the word so its MSB is 1 and decrements the exponent by the shift amount.
- Two-stage registered pipeline with valid/ready handshakes on both sides; feeds the rounding/pack stage.

Parameters:
- WI_SZ, 32, data word width; power of two, >= 4.
- WO_SZ, $clog2(WI_SZ)+1, leading-zero count width; must match the counter's output width.
- EXP_SZ, 8, unsigned exponent width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  WI_SZ  word to normalise.
- in_lzc  input  WO_SZ  leading-zero count of in_data; value WI_SZ means in_data == 0.
- in_exp  input  EXP_SZ  exponent paired with in_data.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_data  output  WI_SZ  normalised word.
- out_exp  output  EXP_SZ  adjusted exponent.
- out_zero  output  1  input word was all zeros.
- out_uflow  output  1  exponent underflow; shift was limited.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_exp=0, out_zero=0, out_uflow=0. in_ready is forced 0 while rst_n=0.
- Stage S1: registers in_data, in_lzc and in_exp on accept; sets s1_valid.
- Stage S2: computes the result from the S1 registers and registers it; s2_valid drives out_valid.
- Latency: 2 cycles from the accept edge to out_valid with no stall. Throughput: 1 beat/cycle.
- Advance rules:
  - s2_adv = s1_valid && (!s2_valid || out_ready).
  - s1_load = in_valid && in_ready.
  - in_ready = !s1_valid || s2_adv.
- No bubbles on continuous flow; a full pipe holds both beats while stalled.
- When not advancing, out_data, out_exp, out_zero and out_uflow hold stable while out_valid=1.
- Arithmetic, evaluated in S2:
  - lzc == WI_SZ: out_zero=1, out_data=0, out_exp=0, out_uflow=0.
  - in_exp >= lzc: out_data = data << lzc, out_exp = in_exp - lzc, out_uflow=0. in_exp == lzc gives out_exp=0, not an underflow.
  - in_exp < lzc: out_uflow=1, out_data = data << in_exp, out_exp=0 (denormal-style partial shift).
  - Shift fills zeros; no sign handling; all compares are unsigned.
- in_lzc > WI_SZ is illegal input. The block clamps it to WI_SZ and treats the word as zero.
- Simultaneous events: a new beat loads into S1 in the same cycle S1 moves to S2; output order always equals input order.
- Reset mid-operation: in-flight beats are discarded; no output appears after rst_n releases until new beats are accepted.

Optional Feature:
- Macro: LZC_NORM_CHECK_EN.
- When defined:
  - Adds output port lzc_err (1 bit, reset 0).
  - S1 recomputes the leading-zero count of its registered data.
  - On a mismatch with the registered lzc while s1_valid=1, lzc_err is set on the next edge and stays set (sticky) until reset.
  - Datapath results are unaffected.
- When undefined: the port and the check logic are absent.

Test Plan:
1. in_data=0x0000_1000, in_lzc=19, in_exp=100, out_ready=1 -> 2 cycles after accept: out_data=0x8000_0000, out_exp=81, out_zero=0, out_uflow=0.
2. in_data=0, in_lzc=32, in_exp=50 -> out_zero=1, out_data=0, out_exp=0, out_uflow=0.
3. in_data=0x0000_0001, in_lzc=31, in_exp=10 -> out_uflow=1, out_exp=0, out_data=0x0000_0400. Also in_exp=31 with the same data -> out_data=0x8000_0000, out_exp=0, out_uflow=0.
4. Backpressure: send 4 back-to-back beats with exp 10,20,30,40 (data=0x8000_0000, lzc=0) and hold out_ready=0 for 3 cycles -> in_ready drops once S1 and S2 are full; out_exp is then delivered 10,20,30,40 with no loss or duplication, and out_data stays stable during the stall.
5. Reset mid-operation: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately and in_ready=0 during reset. After release: in_ready=1 and no output until a new beat is accepted.
6. With LZC_NORM_CHECK_EN: in_data=0x8000_0000, in_lzc=5 -> lzc_err=1 one cycle after S1 load; it stays 1 across following correct beats and clears only on rst_n=0.
